// File: rtl/sap2_core.sv
// sap2_core: parametrised SAP-2 style accumulator CPU core.
//   Multiplexed internal datapath and a 3-bit T-state sequencer (T1..T5).
//   A front-panel port loads program memory while the core is stalled.
//
// Parameters
//   DATA_W : word width of memory, A, B, O and IR (needs DATA_W >= ADDR_W+4)
//   ADDR_W : address width; memory depth is 2**ADDR_W words
//
// Ports
//   sysclk     : system clock, rising edge
//   fp_clear_n : asynchronous active-low clear
//   clken      : step enable; nothing advances on edges where it is low
//   fp_prog    : program mode; stalls the core and addresses memory by fp_adr
//   fp_write   : program-mode write strobe for fp_data -> mem[fp_adr]
//   fp_adr     : program address
//   fp_data    : program data
//   eo_sel     : debug select (0 state, 1 PC, 2 A, 3 IR)
//   extra_out  : debug output, zero-extended
//   o_out      : output register
//   halt       : sticky, set by HLT
//   flags      : {C, Z}
module sap2_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              sysclk,
  input  logic              fp_clear_n,
  input  logic              clken,
  input  logic              fp_prog,
  input  logic              fp_write,
  input  logic [ADDR_W-1:0] fp_adr,
  input  logic [DATA_W-1:0] fp_data,
  input  logic [1:0]        eo_sel,
  output logic [DATA_W-1:0] extra_out,
  output logic [DATA_W-1:0] o_out,
  output logic              halt,
  output logic [1:0]        flags
);

  typedef enum logic [2:0] {
    T1 = 3'd0,
    T2 = 3'd1,
    T3 = 3'd2,
    T4 = 3'd3,
    T5 = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_STA = 4'h3,
    OP_LDI = 4'h4,
    OP_JMP = 4'h5,
    OP_JC  = 4'h6,
    OP_JZ  = 4'h7,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              c;
  logic              z;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_rd;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] operand_ext;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;
  logic              advance;

  assign advance     = clken && !fp_prog && !halt;
  assign mem_adr     = fp_prog ? fp_adr : mar;
  assign mem_rd      = mem[mem_adr];
  assign opcode      = ir[DATA_W-1 -: 4];
  assign operand     = ir[ADDR_W-1:0];
  assign operand_ext = DATA_W'(operand);
  assign sum         = {1'b0, a} + {1'b0, b};
  assign diff        = a - b;

  // Memory has no reset so a program survives fp_clear_n.
  // STA can only fire when fp_prog=0, so the two write sources never collide.
  always_ff @(posedge sysclk) begin
    if (clken) begin
      if (fp_prog) begin
        if (fp_write) mem[fp_adr] <= fp_data;
      end else if (!halt && state == T4 && opcode == OP_STA) begin
        mem[mar] <= a;
      end
    end
  end

  always_ff @(posedge sysclk or negedge fp_clear_n) begin
    if (!fp_clear_n) begin
      state <= T1;
      pc    <= '0;
      mar   <= '0;
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      o_out <= '0;
      c     <= 1'b0;
      z     <= 1'b0;
      halt  <= 1'b0;
    end else if (advance) begin
      case (state)
        T1: begin
          mar   <= pc;
          state <= T2;
        end
        T2: begin
          ir    <= mem_rd;
          pc    <= pc + 1'b1;
          state <= T3;
        end
        T3: begin
          state <= T1;
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              mar   <= operand;
              state <= T4;
            end
            OP_LDI: begin
              a <= operand_ext;
              z <= (operand == '0);
            end
            OP_JMP: pc <= operand;
            OP_JC:  if (c) pc <= operand;
            OP_JZ:  if (z) pc <= operand;
            OP_OUT: o_out <= a;
            OP_HLT: halt <= 1'b1;
            default: ;
          endcase
        end
        T4: begin
          state <= T1;
          case (opcode)
            OP_LDA: begin
              a <= mem_rd;
              z <= (mem_rd == '0);
            end
            OP_ADD, OP_SUB: begin
              b     <= mem_rd;
              state <= T5;
            end
            default: ;
          endcase
        end
        T5: begin
          state <= T1;
          if (opcode == OP_SUB) begin
            a <= diff;
            c <= (a >= b);
            z <= (diff == '0);
          end else begin
            a <= sum[DATA_W-1:0];
            c <= sum[DATA_W];
            z <= (sum[DATA_W-1:0] == '0);
          end
        end
        default: state <= T1;
      endcase
    end
  end

  assign flags = {c, z};

  always_comb begin
    extra_out = '0;
    case (eo_sel)
      2'd0: extra_out = DATA_W'(state);
      2'd1: extra_out = DATA_W'(pc);
      2'd2: extra_out = a;
      2'd3: extra_out = ir;
      default: extra_out = '0;
    endcase
  end

endmodule

// File: tb/tb_sap2_core.sv
module tb_sap2_core;

  logic        sysclk;
  logic        fp_clear_n;
  logic        clken;
  logic        fp_prog;
  logic        fp_write;
  logic [3:0]  fp_adr;
  logic [7:0]  fp_data;
  logic [1:0]  eo_sel;
  logic [7:0]  extra_out;
  logic [7:0]  o_out;
  logic        halt;
  logic [1:0]  flags;

  logic        fp_prog_w;
  logic        fp_write_w;
  logic [7:0]  fp_adr_w;
  logic [11:0] fp_data_w;
  logic [1:0]  eo_sel_w;
  logic [11:0] extra_out_w;
  logic [11:0] o_out_w;
  logic        halt_w;
  logic [1:0]  flags_w;

  int errors = 0;
  int checks = 0;

  sap2_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .sysclk(sysclk), .fp_clear_n(fp_clear_n), .clken(clken),
    .fp_prog(fp_prog), .fp_write(fp_write), .fp_adr(fp_adr), .fp_data(fp_data),
    .eo_sel(eo_sel), .extra_out(extra_out), .o_out(o_out), .halt(halt), .flags(flags)
  );

  sap2_core #(.DATA_W(12), .ADDR_W(8)) dut_w (
    .sysclk(sysclk), .fp_clear_n(fp_clear_n), .clken(clken),
    .fp_prog(fp_prog_w), .fp_write(fp_write_w), .fp_adr(fp_adr_w), .fp_data(fp_data_w),
    .eo_sel(eo_sel_w), .extra_out(extra_out_w), .o_out(o_out_w), .halt(halt_w), .flags(flags_w)
  );

  initial sysclk = 1'b0;
  always #50 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic peek(input logic [1:0] sel, input string tag, input logic [31:0] exp);
    eo_sel = sel;
    #1;
    check(tag, 32'(extra_out), exp);
  endtask

  task automatic peek_w(input logic [1:0] sel, input string tag, input logic [31:0] exp);
    eo_sel_w = sel;
    #1;
    check(tag, 32'(extra_out_w), exp);
  endtask

  task automatic prog(input logic [3:0] adr, input logic [7:0] data);
    fp_prog  = 1'b1;
    fp_write = 1'b1;
    fp_adr   = adr;
    fp_data  = data;
    step(1);
    fp_write = 1'b0;
  endtask

  task automatic prog_w(input logic [7:0] adr, input logic [11:0] data);
    fp_prog_w  = 1'b1;
    fp_write_w = 1'b1;
    fp_adr_w   = adr;
    fp_data_w  = data;
    step(1);
    fp_write_w = 1'b0;
  endtask

  task automatic pulse_reset();
    fp_clear_n = 1'b0;
    #1;
    fp_clear_n = 1'b1;
    #1;
  endtask

  initial begin
    fp_clear_n = 1'b1;
    clken      = 1'b0;
    fp_prog    = 1'b0;
    fp_write   = 1'b0;
    fp_adr     = '0;
    fp_data    = '0;
    eo_sel     = 2'd0;
    fp_prog_w  = 1'b1;
    fp_write_w = 1'b0;
    fp_adr_w   = '0;
    fp_data_w  = '0;
    eo_sel_w   = 2'd0;
    #1;
    fp_clear_n = 1'b0;
    #10;
    check("rst_o_out", 32'(o_out), 32'h0);
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_flags", 32'(flags), 32'h0);
    peek(2'd0, "rst_state", 32'h0);
    peek(2'd1, "rst_pc", 32'h0);
    peek(2'd2, "rst_a", 32'h0);
    fp_clear_n = 1'b1;
    clken = 1'b1;
    step(1);

    // Add and halt: LDA 9, ADD A, OUT, HLT
    prog(4'h0, 8'h09); prog(4'h1, 8'h1A); prog(4'h2, 8'hE0); prog(4'h3, 8'hF0);
    prog(4'h9, 8'h10); prog(4'hA, 8'h0E);
    fp_prog = 1'b0;
    pulse_reset();
    step(14);
    check("add_halt_14", 32'(halt), 32'h0);
    step(1);
    check("add_halt_15", 32'(halt), 32'h1);
    check("add_o_out", 32'(o_out), 32'h1E);
    check("add_flags", 32'(flags), 32'h0);
    peek(2'd2, "add_a", 32'h1E);
    step(5);
    peek(2'd1, "halted_pc", 32'h4);
    peek(2'd0, "halted_state", 32'h0);
    check("halted_o_out", 32'(o_out), 32'h1E);

    // Carry and JC: F0+20 carries, JC to 5
    prog(4'h0, 8'h08); prog(4'h1, 8'h19); prog(4'h2, 8'h65); prog(4'h3, 8'hE0);
    prog(4'h4, 8'hE0); prog(4'h5, 8'hE0); prog(4'h6, 8'hF0);
    prog(4'h8, 8'hF0); prog(4'h9, 8'h20);
    fp_prog = 1'b0;
    pulse_reset();
    step(12);
    peek(2'd2, "jc_a", 32'h10);
    check("jc_flags", 32'(flags), 32'h2);
    peek(2'd1, "jc_pc", 32'h5);
    step(6);
    check("jc_o_out", 32'(o_out), 32'h10);
    check("jc_halt", 32'(halt), 32'h1);
    peek(2'd1, "jc_halt_pc", 32'h7);

    // Zero and JZ: 5-5 takes the jump, 4-5 falls through
    prog(4'h0, 8'h08); prog(4'h1, 8'h29); prog(4'h2, 8'h75); prog(4'h3, 8'hF0);
    prog(4'h8, 8'h05); prog(4'h9, 8'h05);
    fp_prog = 1'b0;
    pulse_reset();
    step(9);
    peek(2'd2, "jz_a", 32'h00);
    check("jz_flags", 32'(flags), 32'h3);
    step(3);
    peek(2'd1, "jz_pc_taken", 32'h5);
    prog(4'h8, 8'h04);
    fp_prog = 1'b0;
    pulse_reset();
    step(9);
    peek(2'd2, "jnz_a", 32'hFF);
    check("jnz_flags", 32'(flags), 32'h0);
    step(3);
    peek(2'd1, "jnz_pc_fall", 32'h3);
    step(3);
    check("jnz_halt", 32'(halt), 32'h1);

    // STA/LDI round trip
    prog(4'h0, 8'h47); prog(4'h1, 8'h3C); prog(4'h2, 8'h40); prog(4'h3, 8'h0C);
    prog(4'h4, 8'hE0); prog(4'h5, 8'hF0);
    fp_prog = 1'b0;
    pulse_reset();
    step(3);
    peek(2'd2, "ldi7_a", 32'h07);
    check("ldi7_flags", 32'(flags), 32'h0);
    step(7);
    peek(2'd2, "ldi0_a", 32'h00);
    check("ldi0_flags", 32'(flags), 32'h1);
    step(4);
    peek(2'd2, "lda_c_a", 32'h07);
    check("lda_c_flags", 32'(flags), 32'h0);
    step(6);
    check("sta_o_out", 32'(o_out), 32'h07);
    check("sta_halt", 32'(halt), 32'h1);

    // PC wrap via JMP F then NOP at F, then clken hold
    prog(4'h0, 8'h5F); prog(4'hF, 8'h80);
    fp_prog = 1'b0;
    pulse_reset();
    step(3);
    peek(2'd1, "jmp_pc", 32'hF);
    step(2);
    peek(2'd1, "wrap_pc", 32'h0);
    peek(2'd0, "wrap_state", 32'h2);
    clken = 1'b0;
    step(10);
    peek(2'd1, "hold_pc", 32'h0);
    peek(2'd0, "hold_state", 32'h2);
    peek(2'd3, "hold_ir", 32'h80);
    clken = 1'b1;

    // Reset during T4 of an ADD
    prog(4'h0, 8'h09); prog(4'h1, 8'hE0); prog(4'h2, 8'h1A); prog(4'h3, 8'hE0);
    prog(4'h4, 8'hF0); prog(4'h9, 8'h10); prog(4'hA, 8'h0E);
    fp_prog = 1'b0;
    pulse_reset();
    step(10);
    peek(2'd0, "mid_state_t4", 32'h3);
    check("mid_o_out", 32'(o_out), 32'h10);
    fp_clear_n = 1'b0;
    #1;
    check("clr_o_out", 32'(o_out), 32'h0);
    check("clr_halt", 32'(halt), 32'h0);
    check("clr_flags", 32'(flags), 32'h0);
    peek(2'd0, "clr_state", 32'h0);
    peek(2'd1, "clr_pc", 32'h0);
    peek(2'd2, "clr_a", 32'h0);
    peek(2'd3, "clr_ir", 32'h0);
    fp_clear_n = 1'b1;
    #1;
    step(18);
    check("rerun_o_out", 32'(o_out), 32'h1E);
    check("rerun_halt", 32'(halt), 32'h1);

    // 12-bit data, 8-bit address build
    fp_prog = 1'b1;
    prog_w(8'h00, 12'h010); prog_w(8'h01, 12'h111); prog_w(8'h02, 12'h5FF);
    prog_w(8'hFF, 12'h800); prog_w(8'h10, 12'h800); prog_w(8'h11, 12'h900);
    fp_prog_w = 1'b0;
    pulse_reset();
    step(9);
    peek_w(2'd2, "w_add_a", 32'h100);
    check("w_add_flags", 32'(flags_w), 32'h2);
    step(3);
    peek_w(2'd1, "w_jmp_pc", 32'hFF);
    step(2);
    peek_w(2'd1, "w_wrap_pc", 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
